// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch client and a
// load/store client. Load/store wins ties, but the fetch side is guaranteed a
// slot after MAX_LS_STREAK consecutive load/store grants while it waits.
// Each access runs grant -> access (held until mem_ready) -> one-cycle
// response, during which the matching done pulse is driven.
//
// state  | meaning
// IDLE   | sample requests, pick a winner, load the mem_* request registers
// IF_ACC | fetch access outstanding on the memory port
// LS_ACC | load/store access outstanding on the memory port
// RESP   | done pulse for the finished access; requests are not sampled
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                grant_ls
);

  localparam int STRB_W = DATA_W / 8;
  // Counter must be able to hold MAX_LS_STREAK itself, since that is the
  // saturation value compared against.
  localparam int SW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  typedef enum logic [1:0] {IDLE, IF_ACC, LS_ACC, RESP} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic          pick_ls;
  logic          pick_if;

  // Arbitration: load/store first unless the fetch side has waited long enough.
  always_comb begin
    pick_ls = ls_req && !(if_req && (streak >= STREAK_MAX));
    pick_if = !pick_ls && if_req;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_ls)      state_nxt = LS_ACC;
        else if (pick_if) state_nxt = IF_ACC;
      end
      IF_ACC:  if (mem_ready) state_nxt = RESP;
      LS_ACC:  if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers, streak counter and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      grant_ls  <= 1'b0;
      streak    <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ls) begin
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            // Loads never carry byte enables onto the port.
            mem_wstrb <= ls_we ? ls_wstrb : STRB_W'(0);
            grant_ls  <= 1'b1;
            if (streak != STREAK_MAX) streak <= streak + SW'(1);
          end else if (pick_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            grant_ls  <= 1'b0;
            streak    <= '0;
          end
        end
        IF_ACC: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
          end
        end
        LS_ACC: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) ls_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Done pulses are decoded from RESP so an async reset kills them at once.
  always_comb begin
    if_done = (state == RESP) && !grant_ls;
    ls_done = (state == RESP) &&  grant_ls;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: the expected grant sequence is queued as
// stimulus is applied; a memory responder model checks each outstanding
// access against the queue head and checks done pulses and read data.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wstrb;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        grant_ls;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LS_STREAK(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .grant_ls(grant_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic        cur_valid;
  logic [31:0] exp_if_rd;
  logic [31:0] exp_ls_rd;
  int          n_cmp;
  int          n_err;
  int          mem_lat;
  int          wait_cnt;
  int          done_cnt;
  int          done_cyc;
  int          cyc;
  logic        force_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push(input logic is_ls, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [31:0] rdata);
    exp_t e;
    e.is_ls = is_ls;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.wstrb = wstrb;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (done_cnt < target) chk("timeout_done", 64'(done_cnt), 64'(target));
  endtask

  // Memory responder and scoreboard: runs on the falling edge.
  initial begin
    exp_t e;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_ready = force_rdy;
      if (rst_n && mem_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          e = exp_q[0];
          chk("grant_ls", grant_ls, e.is_ls);
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("mem_wstrb", mem_wstrb, e.wstrb);
          if (wait_cnt >= mem_lat) begin
            mem_ready = 1'b1;
            mem_rdata = e.rdata;
            cur       = e;
            cur_valid = 1'b1;
            void'(exp_q.pop_front());
          end
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      if (if_done || ls_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!cur_valid) begin
          chk("spurious_done", 1, 0);
        end else begin
          chk("ls_done", ls_done, cur.is_ls);
          chk("if_done", if_done, !cur.is_ls);
          if (!cur.is_ls)   exp_if_rd = cur.rdata;
          else if (!cur.we) exp_ls_rd = cur.rdata;
          chk("if_rdata", if_rdata, exp_if_rd);
          chk("ls_rdata", ls_rdata, exp_ls_rd);
          cur_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    int base;
    int c0;
    n_cmp = 0; n_err = 0; done_cnt = 0; done_cyc = 0; cyc = 0;
    cur_valid = 1'b0; exp_if_rd = '0; exp_ls_rd = '0;
    mem_lat = 0; wait_cnt = 0; force_rdy = 1'b0;
    rst_n = 1'b0;
    if_req = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_grant_ls", grant_ls, 0);
    chk("rst_done", {if_done, ls_done}, 0);
    chk("rst_rdata", {if_rdata, ls_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk); #2;

    // Fetch with two-cycle memory latency.
    mem_lat = 2;
    push(0, 0, 32'h100, 0, 0, 32'h0000_0013);
    if_addr = 32'h100;
    if_req  = 1;
    @(negedge clk); #2;
    chk("req_latency", mem_req, 1);
    wait_dones(1, 20);
    if_req = 0;
    chk("fetch_rdata", if_rdata, 32'h0000_0013);
    @(negedge clk); #2;
    chk("done_one_cycle", {if_done, ls_done}, 0);

    // Store with immediate ready; ls_rdata must keep its reset value.
    mem_lat = 0;
    push(1, 1, 32'h2004, 32'hDEAD_BEEF, 4'hF, 32'h5555_5555);
    ls_we = 1; ls_addr = 32'h2004; ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'hF;
    c0 = cyc;
    ls_req = 1;
    wait_dones(2, 20);
    ls_req = 0;
    chk("occupancy", 64'(done_cyc - c0), 64'd2);
    chk("store_keeps_ls_rdata", ls_rdata, 0);

    // Simultaneous requests: load first, then fetch.
    mem_lat = 1;
    ls_we = 0; ls_addr = 32'h2000; ls_wdata = 32'h1234_5678; ls_wstrb = 4'hF;
    if_addr = 32'h104;
    push(1, 0, 32'h2000, 32'h1234_5678, 4'h0, 32'hA5A5_0001);
    push(0, 0, 32'h104, 0, 0, 32'hA5A5_0002);
    ls_req = 1; if_req = 1;
    wait_dones(3, 20);
    ls_req = 0;
    wait_dones(4, 20);
    if_req = 0;

    // Both held: three load grants, one fetch, then load again.
    mem_lat = 0;
    ls_addr = 32'h3000; if_addr = 32'h400;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) push(0, 0, 32'h400, 0, 0, 32'hF000_0000 + 32'(i));
      else        push(1, 0, 32'h3000, 32'h1234_5678, 4'h0, 32'hB000_0000 + 32'(i));
    end
    ls_req = 1; if_req = 1;
    wait_dones(9, 60);
    ls_req = 0; if_req = 0;
    @(negedge clk); #2;
    chk("streak_queue_empty", 64'(exp_q.size()), 0);

    // Reset in the middle of a load access.
    mem_lat = 5;
    ls_addr = 32'h2008;
    push(1, 0, 32'h2008, 32'h1234_5678, 4'h0, 32'hCCCC_CCCC);
    ls_req = 1;
    repeat (2) @(negedge clk);
    #2;
    chk("pre_rst_mem_req", mem_req, 1);
    rst_n = 0;
    ls_req = 0;
    #1;
    chk("rst_drop_mem_req", mem_req, 0);
    chk("rst_no_ls_done", ls_done, 0);
    chk("rst_grant_ls_mid", grant_ls, 0);
    exp_q.delete();
    cur_valid = 0; exp_if_rd = '0; exp_ls_rd = '0; wait_cnt = 0;
    @(negedge clk); #2;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("no_done_after_rst", {if_done, ls_done}, 0);
    end
    // A stale streak would let the fetch in earlier than the fourth slot.
    base = done_cnt;
    mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(0, 0, 32'h500, 0, 0, 32'hD000_0003);
      else        push(1, 0, 32'h2008, 32'h1234_5678, 4'h0, 32'hD000_0000 + 32'(i));
    end
    if_addr = 32'h500;
    ls_req = 1; if_req = 1;
    wait_dones(base + 4, 60);
    ls_req = 0; if_req = 0;

    // mem_ready while idle is ignored.
    force_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      chk("idle_ready_req", mem_req, 0);
      chk("idle_ready_done", {if_done, ls_done}, 0);
    end
    force_rdy = 0;
    @(negedge clk); #2;

    // Plain fetch afterwards still behaves.
    base = done_cnt;
    push(0, 0, 32'h600, 0, 0, 32'h0BAD_F00D);
    if_addr = 32'h600;
    if_req = 1;
    wait_dones(base + 1, 20);
    if_req = 0;
    @(negedge clk); #2;
    chk("final_if_rdata", if_rdata, 32'h0BAD_F00D);
    chk("final_queue_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
